mandelbrot_frame_sched: RTL

//  Frame sequencer for one shared combinational mandelbrot_alu. Holds a small viewport config
//  (origin, step, iteration limit) and walks the frame in raster order, HRES x VRES pixels.

---
 rtl/mandelbrot_frame_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_frame_sched.sv
// Raster-order frame sequencer around one shared combinational mandelbrot ALU.
// Optional cycle counter output frame_cycles enabled by defining MANDEL_SCHED_CYCLES_EN.
//
// state   | meaning
// S_IDLE  | config writable, waiting for start
// S_ITER  | iterating the current pixel, emitting results as they terminate
// S_DRAIN | last pixel loaded into the output slot, waiting for its handshake
module mandelbrot_frame_sched #(
    parameter int BITWIDTH = 10,
    parameter int CTRWIDTH = 7,
    parameter int HRES     = 640,
    parameter int VRES     = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [BITWIDTH-1:0] cfg_wdata,
    output logic [BITWIDTH-1:0] alu_cr,
    output logic [BITWIDTH-1:0] alu_ci,
    output logic [BITWIDTH-1:0] alu_zr,
    output logic [BITWIDTH-1:0] alu_zi,
    input  logic [BITWIDTH-1:0] alu_out_zr,
    input  logic [BITWIDTH-1:0] alu_out_zi,
    input  logic                alu_size,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [CTRWIDTH-1:0] pix_ctr,
    output logic                pix_eol,
    output logic                pix_eof,
`ifdef MANDEL_SCHED_CYCLES_EN
    output logic [31:0]         frame_cycles,
`endif
    output logic                frame_done
);

    localparam int COLW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int ROWW = (VRES > 1) ? $clog2(VRES) : 1;
    localparam logic [COLW-1:0]     COL_LAST = COLW'(HRES - 1);
    localparam logic [ROWW-1:0]     ROW_LAST = ROWW'(VRES - 1);
    localparam logic [BITWIDTH-1:0] CR_RST   = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [BITWIDTH-1:0] CI_RST   = BITWIDTH'(-(VRES / 2));

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic [BITWIDTH-1:0] cr_origin, ci_origin, step;
    logic [BITWIDTH-1:0] cr_origin_nxt, ci_origin_nxt, step_nxt;
    logic [CTRWIDTH-1:0] max_ctr, max_ctr_nxt;
    logic [BITWIDTH-1:0] cr, ci, zr, zi;
    logic [CTRWIDTH-1:0] ctr;
    logic [COLW-1:0]     col;
    logic [ROWW-1:0]     row;

    logic cfg_load, start_go, term, handshake, slot_free, emit, last_pix, drain_done;

    assign busy       = (state != S_IDLE);
    assign alu_cr     = cr;
    assign alu_ci     = ci;
    assign alu_zr     = zr;
    assign alu_zi     = zi;
    assign cfg_load   = (state == S_IDLE) && cfg_we;
    assign start_go   = (state == S_IDLE) && start && !abort;
    assign term       = alu_size || (ctr == max_ctr);
    assign handshake  = pix_valid && pix_ready;
    assign slot_free  = !pix_valid || pix_ready;
    assign emit       = (state == S_ITER) && term && slot_free && !abort;
    assign last_pix   = (col == COL_LAST) && (row == ROW_LAST);
    assign drain_done = (state == S_DRAIN) && handshake && !abort;

    // Written config is visible to a start in the same cycle.
    always_comb begin
        cr_origin_nxt = cr_origin;
        ci_origin_nxt = ci_origin;
        step_nxt      = step;
        max_ctr_nxt   = max_ctr;
        if (cfg_load) begin
            case (cfg_addr)
                2'd0:    cr_origin_nxt = cfg_wdata;
                2'd1:    ci_origin_nxt = cfg_wdata;
                2'd2:    step_nxt      = cfg_wdata;
                default: max_ctr_nxt   = cfg_wdata[CTRWIDTH-1:0];
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_go) state_nxt = S_ITER;
            S_ITER:  if (emit && last_pix) state_nxt = S_DRAIN;
            S_DRAIN: if (handshake) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_origin  <= CR_RST;
            ci_origin  <= CI_RST;
            step       <= BITWIDTH'(1);
            max_ctr    <= '1;
            cr         <= '0;
            ci         <= '0;
            zr         <= '0;
            zi         <= '0;
            ctr        <= '0;
            col        <= '0;
            row        <= '0;
            pix_valid  <= 1'b0;
            pix_ctr    <= '0;
            pix_eol    <= 1'b0;
            pix_eof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cr_origin  <= cr_origin_nxt;
            ci_origin  <= ci_origin_nxt;
            step       <= step_nxt;
            max_ctr    <= max_ctr_nxt;
            frame_done <= drain_done;

            if (abort) begin
                pix_valid <= 1'b0;
            end else if (emit) begin
                pix_valid <= 1'b1;
                pix_ctr   <= ctr;
                pix_eol   <= (col == COL_LAST);
                pix_eof   <= last_pix;
            end else if (handshake) begin
                pix_valid <= 1'b0;
            end

            if (start_go) begin
                cr  <= cr_origin_nxt;
                ci  <= ci_origin_nxt;
                zr  <= '0;
                zi  <= '0;
                ctr <= '0;
                col <= '0;
                row <= '0;
            end else if ((state == S_ITER) && !abort && !term) begin
                zr  <= alu_out_zr;
                zi  <= alu_out_zi;
                ctr <= ctr + 1'b1;
            end else if (emit) begin
                zr  <= '0;
                zi  <= '0;
                ctr <= '0;
                if (col == COL_LAST) begin
                    col <= '0;
                    cr  <= cr_origin;
                    ci  <= ci + step;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                    cr  <= cr + step;
                end
            end
        end
    end

`ifdef MANDEL_SCHED_CYCLES_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        frame_cycles <= '0;
        else if (start_go) frame_cycles <= '0;
        else if (busy)     frame_cycles <= frame_cycles + 32'd1;
    end
`endif

endmodule
